// File: rtl/escalonador_rr.sv
// rtl/escalonador_rr.sv - round-robin process scheduler with quantum preemption and I/O blocking
//
// Ports:
//   clock, reset         single clock, asynchronous active-high reset
//   cria_valid/cria_pc   create a process at the lowest free slot (accepted when cria_ready)
//   cria_ready           at least one slot is free
//   instr_exec           running process retired one instruction
//   fim_processo         running process terminated
//   instrucao_io         running process blocked on I/O
//   pc_atual             resume PC of the running process, captured while saving
//   io_pronto/io_proc    I/O finished for slot io_proc (BLOQUEADO -> PRONTO)
//   troca_contexto       one-cycle pulse: CPU loads pc_novo
//   pc_novo              PC to load, valid with troca_contexto
//   processo_atual       running or last-run slot id
//   ocioso               no process is running
//   num_processos        number of non-free slots

module escalonador_rr #(
    parameter int N_PROC  = 8,
    parameter int QUANTUM = 20,
    parameter int PC_W    = 32,
    localparam int ID_W   = $clog2(N_PROC),
    localparam int Q_W    = $clog2(QUANTUM)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cria_valid,
    input  logic [PC_W-1:0] cria_pc,
    output logic            cria_ready,
    input  logic            instr_exec,
    input  logic            fim_processo,
    input  logic            instrucao_io,
    input  logic [PC_W-1:0] pc_atual,
    input  logic            io_pronto,
    input  logic [ID_W-1:0] io_proc,
    output logic            troca_contexto,
    output logic [PC_W-1:0] pc_novo,
    output logic [ID_W-1:0] processo_atual,
    output logic            ocioso,
    output logic [ID_W:0]   num_processos
);

    typedef enum logic [1:0] {LIVRE, PRONTO, BLOQUEADO, EXEC} slot_t;
    typedef enum logic [2:0] {OCIOSO, EXECUTA, SALVA, SELECIONA, CARREGA} fsm_t;
    typedef enum logic [1:0] {C_FIM, C_IO, C_PREEMPCAO} causa_t;

    localparam logic [ID_W:0] UM_CNT = {{ID_W{1'b0}}, 1'b1};

    slot_t           slot_st [N_PROC];
    logic [PC_W-1:0] slot_pc [N_PROC];
    fsm_t            estado;
    causa_t          causa;
    logic [Q_W-1:0]  quantum;

    logic            livre_ok;
    logic [ID_W-1:0] livre_id;
    logic            pronto_ok;
    logic [ID_W-1:0] pronto_id;
    logic            algum_pronto;
    logic [ID_W:0]   contagem;

    // Lowest-index free slot; the descending loop leaves the lowest match last.
    always_comb begin
        livre_ok = 1'b0;
        livre_id = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (slot_st[i] == LIVRE) begin
                livre_ok = 1'b1;
                livre_id = ID_W'(i);
            end
        end
    end

    // Round-robin search starting after processo_atual. Offset N_PROC wraps to
    // processo_atual itself and is visited first in the descending loop, so it
    // has the lowest priority; offset 1 is visited last and wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        pronto_ok = 1'b0;
        pronto_id = '0;
        idx       = '0;
        for (int i = N_PROC; i >= 1; i--) begin
            idx = processo_atual + ID_W'(i);
            if (slot_st[idx] == PRONTO) begin
                pronto_ok = 1'b1;
                pronto_id = idx;
            end
        end
    end

    always_comb begin
        algum_pronto = 1'b0;
        contagem     = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (slot_st[i] == PRONTO) algum_pronto = 1'b1;
            if (slot_st[i] != LIVRE)  contagem = contagem + UM_CNT;
        end
    end

    assign cria_ready    = livre_ok;
    assign num_processos = contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= OCIOSO;
            causa          <= C_FIM;
            quantum        <= '0;
            troca_contexto <= 1'b0;
            pc_novo        <= '0;
            processo_atual <= '0;
            ocioso         <= 1'b1;
            for (int i = 0; i < N_PROC; i++) begin
                slot_st[i] <= LIVRE;
                slot_pc[i] <= '0;
            end
        end else begin
            troca_contexto <= 1'b0;

            // Creation only ever targets a LIVRE slot, so it never collides with
            // the slot touched by SALVA or SELECIONA in the same cycle.
            if (cria_valid && livre_ok) begin
                slot_st[livre_id] <= PRONTO;
                slot_pc[livre_id] <= cria_pc;
            end

            case (estado)
                OCIOSO: begin
                    if (algum_pronto) estado <= SELECIONA;
                end
                EXECUTA: begin
                    if (fim_processo) begin
                        causa  <= C_FIM;
                        estado <= SALVA;
                        ocioso <= 1'b1;
                    end else if (instrucao_io) begin
                        causa  <= C_IO;
                        estado <= SALVA;
                        ocioso <= 1'b1;
                    end else if (instr_exec) begin
                        if (quantum == Q_W'(QUANTUM - 1)) begin
                            causa  <= C_PREEMPCAO;
                            estado <= SALVA;
                            ocioso <= 1'b1;
                        end else begin
                            quantum <= quantum + Q_W'(1);
                        end
                    end
                end
                SALVA: begin
                    case (causa)
                        C_FIM: slot_st[processo_atual] <= LIVRE;
                        C_IO: begin
                            slot_st[processo_atual] <= BLOQUEADO;
                            slot_pc[processo_atual] <= pc_atual;
                        end
                        default: begin
                            slot_st[processo_atual] <= PRONTO;
                            slot_pc[processo_atual] <= pc_atual;
                        end
                    endcase
                    estado <= SELECIONA;
                end
                SELECIONA: begin
                    // The load outputs are registered here so that they are
                    // presented during the CARREGA cycle itself.
                    if (pronto_ok) begin
                        estado                <= CARREGA;
                        troca_contexto        <= 1'b1;
                        pc_novo               <= slot_pc[pronto_id];
                        processo_atual        <= pronto_id;
                        slot_st[pronto_id]    <= EXEC;
                        quantum               <= '0;
                        ocioso                <= 1'b0;
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                CARREGA: begin
                    estado <= EXECUTA;
                end
                default: begin
                    estado <= OCIOSO;
                    ocioso <= 1'b1;
                end
            endcase

            // Written last so it overrides the SALVA-IO update of the same slot.
            if (io_pronto) begin
                if (slot_st[io_proc] == BLOQUEADO) begin
                    slot_st[io_proc] <= PRONTO;
                end else if (estado == SALVA && causa == C_IO && io_proc == processo_atual) begin
                    slot_st[io_proc] <= PRONTO;
                end
            end
        end
    end

endmodule

// File: tb/tb_escalonador_rr.sv
// tb/tb_escalonador_rr.sv - self-checking bench for escalonador_rr against a behavioural scheduler model

module tb_escalonador_rr;

    localparam int N = 8;
    localparam int Q = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cria_valid = 1'b0;
    logic [31:0] cria_pc = '0;
    logic        cria_ready;
    logic        instr_exec = 1'b0;
    logic        fim_processo = 1'b0;
    logic        instrucao_io = 1'b0;
    logic [31:0] pc_atual = '0;
    logic        io_pronto = 1'b0;
    logic [2:0]  io_proc = '0;
    logic        troca_contexto;
    logic [31:0] pc_novo;
    logic [2:0]  processo_atual;
    logic        ocioso;
    logic [3:0]  num_processos;

    int total = 0;
    int bad   = 0;

    escalonador_rr #(.N_PROC(N), .QUANTUM(Q), .PC_W(32)) dut (
        .clock         (clk),
        .reset         (rst),
        .cria_valid    (cria_valid),
        .cria_pc       (cria_pc),
        .cria_ready    (cria_ready),
        .instr_exec    (instr_exec),
        .fim_processo  (fim_processo),
        .instrucao_io  (instrucao_io),
        .pc_atual      (pc_atual),
        .io_pronto     (io_pronto),
        .io_proc       (io_proc),
        .troca_contexto(troca_contexto),
        .pc_novo       (pc_novo),
        .processo_atual(processo_atual),
        .ocioso        (ocioso),
        .num_processos (num_processos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Slot kinds: 0 free, 1 ready, 2 blocked, 3 running.
    // m_fase tracks how far a context switch has progressed: 0 nobody running,
    // 1 running, 2 saving, 3 choosing, 4 loading.
    int          m_st [N];
    logic [31:0] m_pc [N];
    int          m_fase, m_cur, m_instr, m_motivo;
    logic        m_pulso;
    logic [31:0] m_pcn;

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = 0;
            m_pc[k] = '0;
        end
        m_fase = 0; m_cur = 0; m_instr = 0; m_motivo = 0;
        m_pulso = 1'b0; m_pcn = '0;
    endtask

    task automatic m_step();
        int  antes [N];
        bit  achou;
        int  idx;
        antes   = m_st;
        m_pulso = 1'b0;
        achou   = 0;
        if (cria_valid) begin
            for (int k = 0; k < N; k++) begin
                if (!achou && antes[k] == 0) begin
                    achou = 1;
                    m_st[k] = 1;
                    m_pc[k] = cria_pc;
                end
            end
        end
        achou = 0;
        case (m_fase)
            0: begin
                for (int k = 0; k < N; k++) if (antes[k] == 1) achou = 1;
                if (achou) m_fase = 3;
            end
            1: begin
                if (fim_processo)      begin m_motivo = 0; m_fase = 2; end
                else if (instrucao_io) begin m_motivo = 1; m_fase = 2; end
                else if (instr_exec) begin
                    m_instr++;
                    if (m_instr == Q) begin m_motivo = 2; m_fase = 2; end
                end
            end
            2: begin
                if (m_motivo == 0) m_st[m_cur] = 0;
                else begin
                    m_st[m_cur] = (m_motivo == 1) ? 2 : 1;
                    m_pc[m_cur] = pc_atual;
                end
                m_fase = 3;
            end
            3: begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_cur + k) % N;
                    if (!achou && antes[idx] == 1) begin
                        achou = 1;
                        m_cur = idx;
                    end
                end
                if (achou) begin
                    m_st[m_cur] = 3;
                    m_pcn   = m_pc[m_cur];
                    m_pulso = 1'b1;
                    m_instr = 0;
                    m_fase  = 4;
                end else begin
                    m_fase = 0;
                end
            end
            default: m_fase = 1;
        endcase
        if (io_pronto && m_st[io_proc] == 2) m_st[io_proc] = 1;
    endtask

    task automatic compare_model();
        int ocupados;
        bit livre;
        ocupados = 0;
        livre = 0;
        for (int k = 0; k < N; k++) begin
            if (m_st[k] != 0) ocupados++;
            else livre = 1;
        end
        check("troca_contexto", 32'(troca_contexto), 32'(m_pulso));
        check("pc_novo", pc_novo, m_pcn);
        check("processo_atual", 32'(processo_atual), 32'(m_cur));
        check("ocioso", 32'(ocioso), 32'(!(m_fase == 1 || m_fase == 4)));
        check("num_processos", 32'(num_processos), 32'(ocupados));
        check("cria_ready", 32'(cria_ready), 32'(livre));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle_inputs();
        cria_valid = 0; instr_exec = 0; fim_processo = 0;
        instrucao_io = 0; io_pronto = 0;
    endtask

    task automatic wait_troca();
        int n = 0;
        while (!troca_contexto && n < 12) begin
            tick();
            n++;
        end
        check("troca_wait", 32'(troca_contexto), 32'd1);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        m_reset();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_troca"}, 32'(troca_contexto), 32'd0);
        check({tag, "_pc_novo"}, pc_novo, 32'd0);
        check({tag, "_proc"}, 32'(processo_atual), 32'd0);
        check({tag, "_ocioso"}, 32'(ocioso), 32'd1);
        check({tag, "_num"}, 32'(num_processos), 32'd0);
        check({tag, "_cria_ready"}, 32'(cria_ready), 32'd1);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // Single creation: pulse in the cycle before the 3rd edge after creation.
        cria_valid = 1; cria_pc = 32'h40;
        tick();
        idle_inputs();
        tick();
        check("one_no_early_pulse", 32'(troca_contexto), 32'd0);
        tick();
        check("one_troca", 32'(troca_contexto), 32'd1);
        check("one_pc_novo", pc_novo, 32'h40);
        check("one_proc", 32'(processo_atual), 32'd0);
        check("one_ocioso", 32'(ocioso), 32'd0);

        // Quantum expiry alternates between two processes.
        cria_valid = 1; cria_pc = 32'h80;
        tick();
        idle_inputs();
        instr_exec = 1; pc_atual = 32'h54;
        for (int i = 0; i < Q; i++) tick();
        idle_inputs();
        wait_troca();
        check("rr_pc_p1", pc_novo, 32'h80);
        check("rr_proc_p1", 32'(processo_atual), 32'd1);
        tick();
        instr_exec = 1; pc_atual = 32'h99;
        for (int i = 0; i < Q; i++) tick();
        idle_inputs();
        wait_troca();
        check("rr_pc_p0", pc_novo, 32'h54);
        check("rr_proc_p0", 32'(processo_atual), 32'd0);

        // FIM, IO and quantum expiry together: FIM wins.
        tick();
        instr_exec = 1; pc_atual = 32'h60;
        for (int i = 0; i < Q - 1; i++) tick();
        fim_processo = 1; instrucao_io = 1;
        tick();
        idle_inputs();
        wait_troca();
        check("prio_num", 32'(num_processos), 32'd1);
        check("prio_proc", 32'(processo_atual), 32'd1);
        check("prio_pc", pc_novo, 32'h99);
        cria_valid = 1; cria_pc = 32'h123;
        tick();
        idle_inputs();
        check("prio_recreate_num", 32'(num_processos), 32'd2);

        // I/O block with a single process, then wake it up.
        do_reset();
        cria_valid = 1; cria_pc = 32'h40;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        instrucao_io = 1; pc_atual = 32'h77;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("io_ocioso", 32'(ocioso), 32'd1);
            check("io_no_pulse", 32'(troca_contexto), 32'd0);
        end
        io_pronto = 1; io_proc = 3'd0;
        tick();
        idle_inputs();
        wait_troca();
        check("io_pc_novo", pc_novo, 32'h77);
        check("io_proc", 32'(processo_atual), 32'd0);

        // Fill every slot, reject an extra creation, free one and refill.
        do_reset();
        for (int i = 0; i < N; i++) begin
            cria_valid = 1; cria_pc = 32'h100 + 32'(i);
            tick();
        end
        idle_inputs();
        check("full_num", 32'(num_processos), 32'd8);
        check("full_ready", 32'(cria_ready), 32'd0);
        cria_valid = 1; cria_pc = 32'hdead;
        tick();
        idle_inputs();
        check("full_reject", 32'(num_processos), 32'd8);
        fim_processo = 1;
        tick();
        idle_inputs();
        tick();
        check("freed_num", 32'(num_processos), 32'd7);
        check("freed_ready", 32'(cria_ready), 32'd1);
        cria_valid = 1; cria_pc = 32'h999;
        tick();
        idle_inputs();
        check("refill_num", 32'(num_processos), 32'd8);

        // Reset during the load cycle kills the pulse.
        do_reset();
        cria_valid = 1; cria_pc = 32'h40;
        tick();
        idle_inputs();
        tick();
        tick();
        check("carrega_pulse_pending", 32'(troca_contexto), 32'd1);
        rst = 1;
        #1;
        m_reset();
        check_reset_values("mid_reset");
        tick();
        rst = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cria_valid   = ($urandom % 4) == 0;
            cria_pc      = $urandom;
            instr_exec   = ($urandom % 2) == 0;
            fim_processo = ($urandom % 40) == 0;
            instrucao_io = ($urandom % 25) == 0;
            pc_atual     = $urandom;
            io_pronto    = ($urandom % 5) == 0;
            io_proc      = 3'($urandom % N);
            rst          = ($urandom % 700) == 0;
            if (rst) m_reset();
            tick();
            rst = 0;
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/escalonador_rr.md
ESCALONADOR_RR -- requirements
Module: escalonador_rr

Interface
REQ-001 Parameter N_PROC, default 8, number of process slots (power of two, 2..16).
REQ-002 Parameter QUANTUM, default 20, instructions per time slice (>=2).
REQ-003 Parameter PC_W, default 32, PC width.
REQ-004 clock  in  1  single clock; all state changes on posedge clock.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 cria_valid  in  1  request to create a process.
REQ-007 cria_pc  in  PC_W  start PC of the new process.
REQ-008 cria_ready  out  1  a free slot exists; creation is accepted when cria_valid & cria_ready.
REQ-009 instr_exec  in  1  the running process retired one instruction this cycle.
REQ-010 fim_processo  in  1  the running process terminated.
REQ-011 instrucao_io  in  1  the running process blocked on I/O.
REQ-012 pc_atual  in  PC_W  resume PC of the running process, sampled on preemption.
REQ-013 io_pronto  in  1  I/O completed for process io_proc.
REQ-014 io_proc  in  log2(N_PROC)  process id for io_pronto.
REQ-015 troca_contexto  out  1  one-cycle pulse: the CPU loads pc_novo.
REQ-016 pc_novo  out  PC_W  PC to load; valid while troca_contexto=1.
REQ-017 processo_atual  out  log2(N_PROC)  id of the running or last-run process.
REQ-018 ocioso  out  1  no process is running.
REQ-019 num_processos  out  log2(N_PROC)+1  count of non-free slots.

Function
REQ-020 Each slot SHALL hold a state (LIVRE, PRONTO, BLOQUEADO, EXEC) and a saved PC.
REQ-021 The FSM SHALL have five states: OCIOSO, EXECUTA, SALVA, SELECIONA, CARREGA.
REQ-022 Creation SHALL be accepted in any FSM state and take the lowest-index LIVRE slot, setting it to PRONTO with saved PC = cria_pc; at most one creation per cycle.
REQ-023 cria_ready SHALL be 1 iff at least one slot is LIVRE.
REQ-024 In OCIOSO, if any slot is PRONTO, the FSM SHALL go to SELECIONA on the next edge; otherwise it SHALL stay and ocioso SHALL be 1.
REQ-025 In EXECUTA, a quantum counter SHALL increment on each instr_exec; when instr_exec=1 with counter=QUANTUM-1, the FSM SHALL go to SALVA with cause PREEMPCAO.
REQ-026 In EXECUTA, fim_processo SHALL cause SALVA with cause FIM, and instrucao_io SHALL cause SALVA with cause IO.
REQ-027 Cause priority for events in the same cycle SHALL be FIM > IO > PREEMPCAO.
REQ-028 fim_processo and instrucao_io SHALL be ignored outside EXECUTA.
REQ-029 In SALVA, the running slot SHALL be updated by cause, and the FSM SHALL then go to SELECIONA:
- FIM: slot becomes LIVRE.
- IO: slot becomes BLOQUEADO and saved PC = pc_atual.
- PREEMPCAO: slot becomes PRONTO and saved PC = pc_atual.
REQ-030 In SELECIONA, the FSM SHALL pick the first PRONTO slot searching from processo_atual+1 modulo N_PROC, wrapping, with processo_atual itself checked last.
- If a slot is found, the FSM SHALL go to CARREGA.
- If none is found, the FSM SHALL go to OCIOSO and processo_atual SHALL hold its value.
REQ-031 In CARREGA, the FSM SHALL perform all of the following in one cycle, then go to EXECUTA:
- assert troca_contexto for exactly one cycle;
- drive pc_novo with the chosen slot's saved PC;
- update processo_atual;
- set the slot to EXEC;
- clear the quantum counter.
REQ-032 A preempted process that is the only PRONTO process SHALL be reselected and SHALL still receive a troca_contexto pulse.
REQ-033 io_pronto SHALL move slot io_proc from BLOQUEADO to PRONTO in any FSM state; if that slot is not BLOQUEADO, io_pronto SHALL have no effect.
REQ-034 If io_pronto targets the slot being set BLOQUEADO in the same SALVA cycle, the slot SHALL end PRONTO.
REQ-035 If a creation and a SALVA-FIM free the same slot in the same cycle, the creation SHALL use the slot state from before that edge.
REQ-036 ocioso SHALL be 1 in OCIOSO, SELECIONA and SALVA, and 0 in CARREGA and EXECUTA.
REQ-037 Latency from a terminating event in EXECUTA to the troca_contexto pulse SHALL be exactly 3 cycles (SALVA, SELECIONA, CARREGA).
REQ-038 num_processos SHALL update on the edge after a creation or a FIM.

Reset
REQ-039 While reset=1 (asynchronous), the block SHALL hold:
- FSM in OCIOSO;
- all slots LIVRE with saved PC 0;
- quantum counter 0;
- troca_contexto=0, pc_novo=0, processo_atual=0;
- ocioso=1, num_processos=0, cria_ready=1.
REQ-040 Reset asserted mid-operation (e.g. during CARREGA) SHALL suppress any pending troca_contexto pulse.

Verification
REQ-041 Reset, then create one process (cria_pc=0x40) -> troca_contexto pulse with pc_novo=0x40, processo_atual=0 on the 3rd edge after creation, ocioso=0.
REQ-042 Create processes with PCs 0x40 and 0x80, then drive QUANTUM=20 instr_exec pulses with pc_atual=0x54 -> switch to process 1 with pc_novo=0x80; after 20 more instructions, switch back to process 0 with pc_novo=0x54.
REQ-043 Fill all 8 slots -> cria_ready=0 and num_processos=8; a further cria_valid is not accepted; one FIM -> cria_ready=1 and the next creation takes the freed slot.
REQ-044 A single process issues instrucao_io -> ocioso=1 and no pulse; io_pronto with io_proc=0 -> pulse with pc_novo equal to the saved pc_atual.
REQ-045 fim_processo and instrucao_io in the same cycle as quantum expiry -> slot becomes LIVRE (not BLOQUEADO or PRONTO) and num_processos decrements by 1.
REQ-046 Assert reset in the CARREGA cycle -> no troca_contexto pulse, all outputs at their reset values.
